// File: rtl/tetris_pkg.sv
// Shared types and colour constants for the playfield renderer.
package tetris_pkg;

  localparam int GRID_W = 10;
  localparam int GRID_H = 20;

  typedef logic [3:0] cell_t;
  typedef logic [3:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  typedef enum logic [1:0] {RG_OFF, RG_PF, RG_WALL} region_t;

  localparam rgb_t RGB_BLACK    = 12'h000;
  localparam rgb_t RGB_BG       = 12'h112;
  localparam rgb_t RGB_GRIDLINE = 12'h223;
  localparam rgb_t RGB_I        = 12'h0FF;
  localparam rgb_t RGB_O        = 12'hFF0;
  localparam rgb_t RGB_T        = 12'hA0F;
  localparam rgb_t RGB_S        = 12'h0F0;
  localparam rgb_t RGB_Z        = 12'hF00;
  localparam rgb_t RGB_J        = 12'h00F;
  localparam rgb_t RGB_L        = 12'hF80;
  localparam rgb_t RGB_GREY     = 12'h888;

  function automatic rgb_t rgb_half(input rgb_t c);
    return {1'b0, c.r[3:1], 1'b0, c.g[3:1], 1'b0, c.b[3:1]};
  endfunction

endpackage

// File: rtl/tetris_palette.sv
// Cell code plus in-cell position to colour, including gridlines and bevel shading.
module tetris_palette
  import tetris_pkg::*;
#(
  parameter int CELL = 24
) (
  input  cell_t      code,
  input  logic [4:0] sub_x,
  input  logic [4:0] sub_y,
  output rgb_t       rgb
);

  localparam logic [4:0] SUB_LAST = 5'(CELL - 1);

  rgb_t base;

  always_comb begin
    base = RGB_GREY;
    case (code)
      4'd0:    base = (sub_x == 5'd0 || sub_y == 5'd0) ? RGB_GRIDLINE : RGB_BG;
      4'd1:    base = RGB_I;
      4'd2:    base = RGB_O;
      4'd3:    base = RGB_T;
      4'd4:    base = RGB_S;
      4'd5:    base = RGB_Z;
      4'd6:    base = RGB_J;
      4'd7:    base = RGB_L;
      default: base = RGB_GREY;
    endcase
    rgb = base;
    // Bottom/right edge of a filled block is darkened for a bevelled look
    if (code != 4'd0 && (sub_x == SUB_LAST || sub_y == SUB_LAST)) begin
      rgb = rgb_half(base);
    end
  end

endmodule

// File: rtl/tetris_grid_renderer.sv
// Renders the 10x20 playfield from a per-frame shadow copy of the grid, 2-cycle pipeline.
module tetris_grid_renderer
  import tetris_pkg::*;
#(
  parameter int PF_X0     = 200,
  parameter int PF_Y0     = 0,
  parameter int CELL      = 24,
  parameter int BORDER    = 4,
  parameter int SNAP_LINE = 480
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  cell_t      grid [GRID_W][GRID_H],
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       vde,
  output logic       hs_out,
  output logic       vs_out,
  output logic       vde_out,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue
);

  localparam logic [9:0] X0       = 10'(PF_X0);
  localparam logic [9:0] X_END    = 10'(PF_X0 + GRID_W * CELL - 1);
  localparam logic [9:0] WALL_L   = 10'(PF_X0 - BORDER);
  localparam logic [9:0] WALL_R   = 10'(PF_X0 + GRID_W * CELL + BORDER - 1);
  localparam logic [9:0] Y0       = 10'(PF_Y0);
  localparam logic [9:0] Y_END    = 10'(PF_Y0 + GRID_H * CELL - 1);
  localparam logic [9:0] SNAP_Y   = 10'(SNAP_LINE);
  localparam logic [4:0] SUB_LAST = 5'(CELL - 1);
  localparam logic [3:0] COL_OUT  = 4'(GRID_W);
  localparam logic [4:0] ROW_OUT  = 5'(GRID_H);

  cell_t      shadow_q [GRID_W][GRID_H];
  cell_t      shadow_d [GRID_W][GRID_H];
  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [4:0] sx_q, sx_d, sy_q, sy_d;
  logic       in_pf_x;
  region_t    region_d;
  cell_t      code_d;

  cell_t      p1_code_q;
  logic [4:0] p1_sx_q, p1_sy_q;
  region_t    p1_region_q;
  logic       p1_vde_q, p1_hs_q, p1_vs_q;

  rgb_t       pal_rgb, rgb_d, rgb_q;
  logic       hs_q, vs_q, vde_q;

  always_comb begin
    shadow_d = shadow_q;
    if (DrawX == 10'd0 && DrawY == SNAP_Y) begin
      shadow_d = grid;
    end
  end

  // col/row below describe the pixel currently on DrawX/DrawY; the _q copies hold the previous one
  always_comb begin
    in_pf_x = (DrawX >= X0) && (DrawX <= X_END);
    col_d = col_q;
    sx_d  = sx_q;
    if (DrawX == X0) begin
      col_d = 4'd0;
      sx_d  = 5'd0;
    end else if (!in_pf_x) begin
      col_d = COL_OUT;
      sx_d  = 5'd0;
    end else if (col_q < COL_OUT) begin
      if (sx_q == SUB_LAST) begin
        sx_d  = 5'd0;
        col_d = col_q + 4'd1;
      end else begin
        sx_d = sx_q + 5'd1;
      end
    end

    row_d = row_q;
    sy_d  = sy_q;
    if (DrawX == 10'd0) begin
      if (DrawY == Y0) begin
        row_d = 5'd0;
        sy_d  = 5'd0;
      end else if (DrawY > Y_END) begin
        row_d = ROW_OUT;
        sy_d  = 5'd0;
      end else if (row_q < ROW_OUT) begin
        if (sy_q == SUB_LAST) begin
          sy_d  = 5'd0;
          row_d = row_q + 5'd1;
        end else begin
          sy_d = sy_q + 5'd1;
        end
      end
    end
  end

  always_comb begin
    region_d = RG_OFF;
    if (col_d < COL_OUT && row_d < ROW_OUT) begin
      region_d = RG_PF;
    end else if (row_d < ROW_OUT &&
                 ((DrawX >= WALL_L && DrawX < X0) || (DrawX > X_END && DrawX <= WALL_R))) begin
      region_d = RG_WALL;
    end
    code_d = (region_d == RG_PF) ? shadow_q[col_d][row_d] : 4'd0;
  end

  tetris_palette #(.CELL(CELL)) u_palette (
    .code  (p1_code_q),
    .sub_x (p1_sx_q),
    .sub_y (p1_sy_q),
    .rgb   (pal_rgb)
  );

  always_comb begin
    rgb_d = RGB_BLACK;
    if (p1_vde_q) begin
      case (p1_region_q)
        RG_PF:   rgb_d = pal_rgb;
        RG_WALL: rgb_d = RGB_GREY;
        default: rgb_d = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      for (int c = 0; c < GRID_W; c++) begin
        for (int r = 0; r < GRID_H; r++) begin
          shadow_q[c][r] <= 4'd0;
        end
      end
      col_q       <= 4'd0;
      row_q       <= 5'd0;
      sx_q        <= 5'd0;
      sy_q        <= 5'd0;
      p1_code_q   <= 4'd0;
      p1_sx_q     <= 5'd0;
      p1_sy_q     <= 5'd0;
      p1_region_q <= RG_OFF;
      p1_vde_q    <= 1'b0;
      p1_hs_q     <= 1'b1;
      p1_vs_q     <= 1'b1;
      rgb_q       <= RGB_BLACK;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      vde_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      p1_code_q   <= code_d;
      p1_sx_q     <= sx_d;
      p1_sy_q     <= sy_d;
      p1_region_q <= region_d;
      p1_vde_q    <= vde;
      p1_hs_q     <= hsync;
      p1_vs_q     <= vsync;
      rgb_q       <= rgb_d;
      hs_q        <= p1_hs_q;
      vs_q        <= p1_vs_q;
      vde_q       <= p1_vde_q;
    end
  end

  assign Red     = rgb_q.r;
  assign Green   = rgb_q.g;
  assign Blue    = rgb_q.b;
  assign hs_out  = hs_q;
  assign vs_out  = vs_q;
  assign vde_out = vde_q;

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Directed bench for the playfield renderer: pixel table plus snapshot, sync and reset sequences.
module tb_tetris_grid_renderer;

  logic       vga_clk;
  logic       Reset;
  logic [3:0] grid [10][20];
  logic [9:0] DrawX, DrawY;
  logic       hsync, vsync, vde;
  logic       hs_out, vs_out, vde_out;
  logic [3:0] Red, Green, Blue;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    int         x;
    int         y;
    bit         v;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [14];

  tetris_grid_renderer dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .grid    (grid),
    .DrawX   (DrawX),
    .DrawY   (DrawY),
    .hsync   (hsync),
    .vsync   (vsync),
    .vde     (vde),
    .hs_out  (hs_out),
    .vs_out  (vs_out),
    .vde_out (vde_out),
    .Red     (Red),
    .Green   (Green),
    .Blue    (Blue)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic drive(input int x, input int y, input bit v);
    DrawX = 10'(x);
    DrawY = 10'(y);
    vde   = v;
    hsync = 1'b1;
    vsync = 1'b1;
    @(posedge vga_clk);
    #1;
  endtask

  // Raster walk: frame start, one line-start per line down to y, then across the row to x
  task automatic goto_px(input int x, input int y, input bit v);
    drive(0, 0, 1'b0);
    for (int yy = 1; yy <= y; yy++) drive(0, yy, 1'b0);
    if (x >= 200) begin
      for (int xx = 200; xx < x; xx++) drive(xx, y, 1'b1);
    end
    drive(x, y, v);
  endtask

  task automatic check_px(input string name, input int x, input int y, input bit v,
                          input logic [11:0] exp);
    goto_px(x, y, v);
    @(posedge vga_clk);
    #1;
    chk(name, {Red, Green, Blue}, exp);
  endtask

  logic h_hist [10];
  logic v_hist [10];
  logic d_hist [10];

  initial begin
    tbl[0]  = '{"pf_I_cell",      205,   5, 1'b1, 12'h0FF};
    tbl[1]  = '{"pf_I_bevel_x",   223,   5, 1'b1, 12'h077};
    tbl[2]  = '{"pf_I_bevel_y",   215,  23, 1'b1, 12'h077};
    tbl[3]  = '{"pf_I_sub0",      200,   5, 1'b1, 12'h0FF};
    tbl[4]  = '{"gridline_x",     224,   0, 1'b1, 12'h223};
    tbl[5]  = '{"gridline_y",     205,  24, 1'b1, 12'h223};
    tbl[6]  = '{"last_cell_L",    439, 479, 1'b1, 12'h740};
    tbl[7]  = '{"wall_r_first",   440, 100, 1'b1, 12'h888};
    tbl[8]  = '{"wall_r_last",    443, 100, 1'b1, 12'h888};
    tbl[9]  = '{"past_wall_r",    444, 100, 1'b1, 12'h000};
    tbl[10] = '{"wall_l_inner",   197, 240, 1'b1, 12'h888};
    tbl[11] = '{"wall_l_outer",   196, 240, 1'b1, 12'h888};
    tbl[12] = '{"left_of_wall",   195, 240, 1'b1, 12'h000};
    tbl[13] = '{"vde_low",        300, 100, 1'b0, 12'h000};

    for (int c = 0; c < 10; c++)
      for (int r = 0; r < 20; r++)
        grid[c][r] = 4'd0;

    // Reset held 3 cycles with inverted sync/enable inputs
    Reset = 1'b1;
    DrawX = 10'd300;
    DrawY = 10'd100;
    hsync = 1'b0;
    vsync = 1'b0;
    vde   = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("reset_rgb", {Red, Green, Blue}, 12'h000);
    chk("reset_sync", {9'd0, hs_out, vs_out, vde_out}, 12'h006);
    Reset = 1'b0;

    check_px("empty_bg", 300, 100, 1'b1, 12'h112);

    grid[0][0]  = 4'd1;
    grid[9][19] = 4'd7;
    drive(0, 480, 1'b0);

    for (int i = 0; i < 14; i++) begin
      check_px(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].exp);
    end

    // Grid write mid-frame must stay invisible until the next snapshot line
    goto_px(0, 300, 1'b0);
    grid[4][10] = 4'd2;
    check_px("no_tear_before_snap", 300, 245, 1'b1, 12'h112);
    drive(0, 480, 1'b0);
    check_px("O_after_snap", 300, 245, 1'b1, 12'hFF0);

    // Syncs and enable emerge two cycles late
    for (int i = 0; i < 10; i++) begin
      h_hist[i] = 1'($urandom_range(0, 1));
      v_hist[i] = 1'($urandom_range(0, 1));
      d_hist[i] = 1'($urandom_range(0, 1));
      DrawX = 10'd700;
      DrawY = 10'd100;
      hsync = h_hist[i];
      vsync = v_hist[i];
      vde   = d_hist[i];
      @(posedge vga_clk);
      #1;
      if (i >= 1) begin
        chk("sync_delay", {9'd0, hs_out, vs_out, vde_out},
            {9'd0, h_hist[i-1], v_hist[i-1], d_hist[i-1]});
      end
    end

    // One-cycle reset in the middle of a line clears shadow and counters
    goto_px(300, 200, 1'b1);
    Reset = 1'b1;
    drive(300, 200, 1'b1);
    Reset = 1'b0;
    chk("midreset_rgb", {Red, Green, Blue}, 12'h000);
    chk("midreset_sync", {9'd0, hs_out, vs_out, vde_out}, 12'h006);
    drive(0, 201, 1'b0);
    for (int xx = 200; xx < 205; xx++) drive(xx, 201, 1'b1);
    drive(205, 201, 1'b1);
    @(posedge vga_clk);
    #1;
    chk("midreset_next_line", {Red, Green, Blue}, 12'h112);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
